// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, issues in-order requests to
//            instruction memory, buffers returned words in a small prefetch
//            buffer, and presents an IF/ID register to decode. EX redirects
//            flush the buffer. Responses that are still in flight are then
//            discarded. Decode stalls hold the IF/ID register.
// Ports    : i_clk, i_reset (async, active-low)
//            i_stall, i_redirect, i_redirect_pc         - pipeline control
//            o_imem_req, o_imem_addr, i_imem_ready      - request channel
//            i_imem_rvalid, i_imem_rdata                - in-order responses
//            o_id_valid, o_id_instr, o_id_pc, o_id_pc4  - IF/ID register
//            o_misalign                                 - only with IF_MISALIGN_EN
// Config   : `define IF_MISALIGN_EN adds the sticky o_misalign flag. A redirect
//            to a target that is not word-aligned then halts fetch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
`ifdef IF_MISALIGN_EN
    output logic        o_misalign,
`endif
    output logic        o_id_valid,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc4
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW:0]   CRED_MAX = (CW+1)'(BUF_DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]    state;
    logic [31:0]   pc;        // next address to request
    logic [31:0]   resp_pc;   // PC of the next live response
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];

    logic          halt;
    logic [31:0]   target;
    logic [CW:0]   credits_used;
    logic          accept;
    logic          resp;
    logic          drop;
    logic          id_load;
    logic          pop;
    logic          bypass;
    logic          push;
    logic [CW-1:0] remaining;
    logic [CW-1:0] discard_dec;

    assign target = {i_redirect_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_EN
    logic misalign;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            misalign <= 1'b0;
        end else if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end

    assign o_misalign = misalign;
    assign halt       = misalign;
`else
    logic unused_pc_low;
    assign unused_pc_low = ^i_redirect_pc[1:0];
    assign halt          = 1'b0;
`endif

    // Credit rule: in-flight requests plus buffered words never exceed the
    // buffer size, so a response always has a slot to land in.
    assign credits_used = {1'b0, outstanding} + {1'b0, count};

    // Reset gates the request so it reads low while reset is held.
    assign o_imem_req  = i_reset && (state == ST_RUN) && !i_redirect && !halt
                         && (credits_used < CRED_MAX);
    assign o_imem_addr = pc;
    assign accept      = o_imem_req && i_imem_ready;

    // Responses with nothing tracked (e.g. issued before reset) are ignored.
    assign resp    = i_imem_rvalid && (state == ST_RUN) && (outstanding != '0);
    assign drop    = i_imem_rvalid && (state == ST_FLUSH) && (discard != '0);

    assign id_load = !(i_stall && o_id_valid);
    assign pop     = id_load && (count != '0);
    assign bypass  = id_load && (count == '0) && resp;
    assign push    = resp && !bypass;

    // In RUN the discard count is zero. In FLUSH no new requests are issued,
    // so outstanding is zero. The sum is therefore the true in-flight count.
    assign remaining   = outstanding + discard - ((resp || drop) ? CNT_ONE : '0);
    assign discard_dec = drop ? (discard - CNT_ONE) : discard;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            o_id_valid  <= 1'b0;
            o_id_instr  <= NOP_INSTR;
            o_id_pc     <= RESET_PC;
            o_id_pc4    <= RESET_PC + 32'd4;
        end else if (i_redirect) begin
            pc          <= target;
            resp_pc     <= target;
            outstanding <= '0;
            discard     <= remaining;
            state       <= (remaining != '0) ? ST_FLUSH : ST_RUN;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            o_id_valid  <= 1'b0;
            o_id_instr  <= NOP_INSTR;
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + (accept ? CNT_ONE : '0) - (resp ? CNT_ONE : '0);
            if (resp) begin
                resp_pc <= resp_pc + 32'd4;
            end
            discard <= discard_dec;
            if ((state == ST_FLUSH) && (discard_dec == '0)) begin
                state <= ST_RUN;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

            if (id_load) begin
                if (pop) begin
                    o_id_valid <= 1'b1;
                    o_id_instr <= buf_instr[rd_ptr];
                    o_id_pc    <= buf_pc[rd_ptr];
                    o_id_pc4   <= buf_pc[rd_ptr] + 32'd4;
                end else if (bypass) begin
                    o_id_valid <= 1'b1;
                    o_id_instr <= i_imem_rdata;
                    o_id_pc    <= resp_pc;
                    o_id_pc4   <= resp_pc + 32'd4;
                end else begin
                    o_id_valid <= 1'b0;
                    o_id_instr <= NOP_INSTR;
                end
            end
        end
    end

    // Buffer storage needs no reset; count and the pointers define its content.
    always_ff @(posedge i_clk) begin
        if (push && !i_redirect) begin
            buf_instr[wr_ptr] <= i_imem_rdata;
            buf_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A behavioural memory answers
//            requests in order with a programmable latency. A scoreboard holds
//            the PC stream decode should see and compares every consumed
//            IF/ID entry against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef IF_MISALIGN_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2),
        .NOP_INSTR (NOP)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ready  (ready),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
`ifdef IF_MISALIGN_EN
        .o_misalign    (misalign),
`endif
        .o_id_valid    (id_valid),
        .o_id_instr    (id_instr),
        .o_id_pc       (id_pc),
        .o_id_pc4      (id_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    mreq_t ment;
    int    cyc = 0;
    int    lat = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            cyc = 0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            cyc = cyc + 1;
            if (imem_req && ready) begin
                ment.addr = imem_addr;
                ment.due  = cyc + lat - 1;
                mq.push_back(ment);
            end
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                ment = mq.pop_front();
                rvalid <= 1'b1;
                rdata  <= word_at(ment.addr);
            end else begin
                rvalid <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    task automatic set_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(i * 4));
    endtask

    // An entry is consumed when it is valid and decode neither stalls nor
    // squashes it with a redirect.
    always @(negedge clk) begin
        #3;
        if (rst_n && id_valid && !stall && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: consumed pc=%h with nothing expected", id_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (id_pc !== mon_exp || id_instr !== word_at(mon_exp) || id_pc4 !== mon_exp + 32'd4) begin
                    errors++;
                    $display("FAIL sb_stream: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h",
                             id_pc, id_instr, id_pc4, mon_exp, word_at(mon_exp), mon_exp + 32'd4);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
        repeat (2) @(negedge clk);
        set_stream(32'h0);
        rst_n = 1'b1;
    endtask

    // Called at negedge+1; returns at posedge+1 with redirect released.
    task automatic pulse_redirect(input logic [31:0] tgt, input logic with_stall);
        redirect = 1'b1; redirect_pc = tgt; stall = with_stall;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL redirect_req_suppressed: got %b want 0", imem_req);
        end
        @(posedge clk); #1;
        redirect = 1'b0; stall = 1'b0;
    endtask

    // Counts rvalid pulses until the fetch unit requests again.
    task automatic count_drops(input int want, input string tag);
        int dropped = 0;
        int n = 0;
        while (imem_req !== 1'b1 && n < 30) begin
            if (rvalid) dropped++;
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 30 || dropped != want) begin
            errors++; $display("FAIL %s_drops: got %0d (loops %0d) want %0d", tag, dropped, n, want);
        end
    endtask

    task automatic wait_valid_pc(input logic [31:0] want_pc, input string tag);
        int n = 0;
        while (!(id_valid === 1'b1 && id_pc === want_pc) && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++; $display("FAIL %s_timeout: last pc=%h valid=%b want pc=%h", tag, id_pc, id_valid, want_pc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
        repeat (2) @(negedge clk); #1;
        checks += 5;
        if (imem_req !== 1'b0)        begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        if (id_valid !== 1'b0)        begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        if (id_instr !== NOP)         begin errors++; $display("FAIL reset_instr: got %h want %h", id_instr, NOP); end
        if (id_pc !== 32'h0)          begin errors++; $display("FAIL reset_pc: got %h want 0", id_pc); end
        if (id_pc4 !== 32'h4)         begin errors++; $display("FAIL reset_pc4: got %h want 4", id_pc4); end
    endtask

    task automatic test_sequential();
        lat = 1;
        do_reset();
        #1;
        checks += 2;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL seq_c0_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        if (id_valid !== 1'b0) begin errors++; $display("FAIL seq_c0_valid: got %b want 0", id_valid); end
        @(negedge clk); #1;
        checks += 2;
        if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_c1_addr: got %h want 4", imem_addr); end
        if (id_valid !== 1'b0)   begin errors++; $display("FAIL seq_c1_valid: got %b want 0", id_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks += 2;
            if (imem_addr !== 32'(8 + 4 * i)) begin
                errors++; $display("FAIL seq_addr: got %h want %h", imem_addr, 32'(8 + 4 * i));
            end
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)) begin
                errors++; $display("FAIL seq_id_pc: got valid=%b pc=%h want 1/%h", id_valid, id_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        wait_valid_pc(32'h10, "stall_find");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h10) begin
                errors++; $display("FAIL stall_hold: got valid=%b pc=%h want 1/10", id_valid, id_pc);
            end
            if (i == 2) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req: got %b want 0", imem_req); end
            end
            @(negedge clk); #1;
        end
        stall = 1'b0;
        wait_valid_pc(32'h20, "stall_resume");
    endtask

    task automatic test_redirect_flush();
        int n = 0;
        lat = 3;
        do_reset();
        while (!(mq.size() == 2 && !rvalid) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL flush_setup: in-flight=%0d want 2", mq.size()); end
        set_stream(32'h100);
        pulse_redirect(32'h100, 1'b0);
        @(negedge clk); #1;
        checks += 2;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", id_valid); end
        if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_req: got %b want 0", imem_req); end
        count_drops(2, "flush");
        checks++;
        if (imem_addr !== 32'h100) begin errors++; $display("FAIL flush_addr: got %h want 100", imem_addr); end
        wait_valid_pc(32'h100, "flush_first");
    endtask

    task automatic test_redirect_stall();
        int n = 0;
        int want_drop;
        wait_valid_pc(32'h104, "rs_find");
        stall = 1'b1;
        while (!(rvalid && mq.size() >= 1) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks += 2;
        if (n >= 20) begin errors++; $display("FAIL rs_setup: no rvalid with in-flight behind it"); end
        if (id_valid !== 1'b1) begin errors++; $display("FAIL rs_held_valid: got %b want 1", id_valid); end
        want_drop = mq.size();
        set_stream(32'h200);
        pulse_redirect(32'h200, 1'b1);
        @(negedge clk); #1;
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP) begin
            errors++; $display("FAIL rs_valid: got valid=%b instr=%h want 0/%h", id_valid, id_instr, NOP);
        end
        count_drops(want_drop, "rs");
        wait_valid_pc(32'h200, "rs_first");
    endtask

    task automatic test_ready_low();
        logic [31:0] a0;
        lat = 1;
        do_reset();
        wait_valid_pc(32'h0, "rl_start");
        ready = 1'b0;
        a0 = imem_addr;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_addr !== a0) begin errors++; $display("FAIL rl_addr: got %h want %h", imem_addr, a0); end
            if (i == 4) begin
                checks++;
                if (id_valid !== 1'b0 || id_instr !== NOP) begin
                    errors++; $display("FAIL rl_idle: got valid=%b instr=%h want 0/%h", id_valid, id_instr, NOP);
                end
            end
            @(negedge clk); #1;
        end
        ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a0) begin
            errors++; $display("FAIL rl_resume: got req=%b addr=%h want 1/%h", imem_req, imem_addr, a0);
        end
        wait_valid_pc(a0, "rl_resume_id");
    endtask

    task automatic test_pc_wrap();
        @(negedge clk); #1;
        set_stream(32'hFFFF_FFF8);
        pulse_redirect(32'hFFFF_FFF8, 1'b0);
        wait_valid_pc(32'hFFFF_FFFC, "wrap_find");
        checks++;
        if (id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", id_pc4); end
        @(negedge clk); #1;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got valid=%b pc=%h want 1/0", id_valid, id_pc);
        end
    endtask

`ifdef IF_MISALIGN_EN
    task automatic test_misalign();
        int n = 0;
        lat = 3;
        do_reset();
        #1;
        checks++;
        if (misalign !== 1'b0) begin errors++; $display("FAIL mis_reset: got %b want 0", misalign); end
        while (!(mq.size() >= 1) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        exp_q.delete();
        pulse_redirect(32'h102, 1'b0);
        @(negedge clk); #1;
        checks += 3;
        if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", misalign); end
        if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", imem_req); end
        if (imem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr: got %h want 100", imem_addr); end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (misalign !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL mis_rst_flags: got mis=%b req=%b want 0/0", misalign, imem_req);
        end
        if (id_valid !== 1'b0) begin errors++; $display("FAIL mis_rst_valid: got %b want 0", id_valid); end
        if (id_instr !== NOP)  begin errors++; $display("FAIL mis_rst_instr: got %h want %h", id_instr, NOP); end
        if (id_pc !== 32'h0)   begin errors++; $display("FAIL mis_rst_pc: got %h want 0", id_pc); end
        if (id_pc4 !== 32'h4)  begin errors++; $display("FAIL mis_rst_pc4: got %h want 4", id_pc4); end
        do_reset();
        wait_valid_pc(32'h0, "mis_restart");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_redirect_stall();
        test_ready_low();
        test_pc_wrap();
`ifdef IF_MISALIGN_EN
        test_misalign();
`endif
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
